// File: rtl/instr_fetch_if.sv
// Bundles the fetch unit's connections to the program counter, instruction memory,
// branch unit and decode stage. Only the clock and the clear stay outside it.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]  PC_Out;
  logic                   PC_Clr;
  logic                   PC_Inc;
  logic                   PC_Load;
  logic [ADDR_WIDTH-1:0]  Dest_Reg;
  logic                   Branch_Take;
  logic [ADDR_WIDTH-1:0]  Branch_Target;
  logic                   Stall;
  logic                   Mem_Req;
  logic [ADDR_WIDTH-1:0]  Mem_Addr;
  logic                   Mem_Ack;
  logic [INSTR_WIDTH-1:0] Mem_Data;
  logic [INSTR_WIDTH-1:0] IR_Out;
  logic                   IR_Valid;
  logic                   IR_Ready;
  logic                   Fetch_Err;

  modport master (
    input  PC_Out, Branch_Take, Branch_Target, Stall, Mem_Ack, Mem_Data, IR_Ready,
    output PC_Clr, PC_Inc, PC_Load, Dest_Reg, Mem_Req, Mem_Addr, IR_Out, IR_Valid, Fetch_Err
  );

  modport slave (
    output PC_Out, Branch_Take, Branch_Target, Stall, Mem_Ack, Mem_Data, IR_Ready,
    input  PC_Clr, PC_Inc, PC_Load, Dest_Reg, Mem_Req, Mem_Addr, IR_Out, IR_Valid, Fetch_Err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word per PC value, handles memory timeout,
// decode backpressure and branch redirects. Every output comes straight from a register.
module instr_fetch #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int TIMEOUT     = 8
) (
  input  logic          Clk,
  input  logic          IF_Clr,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             count_q, count_d;
  logic                   memReq_q, memReq_d;
  logic [ADDR_WIDTH-1:0]  memAddr_q, memAddr_d;
  logic [INSTR_WIDTH-1:0] irOut_q, irOut_d;
  logic                   irValid_q, irValid_d;
  logic                   pcClr_q, pcClr_d;
  logic                   pcInc_q, pcInc_d;
  logic                   pcLoad_q, pcLoad_d;
  logic [ADDR_WIDTH-1:0]  destReg_q, destReg_d;
  logic                   fetchErr_q, fetchErr_d;
  logic                   pcBusy;

  // A pending clear/increment/load means PC_Out changes on the coming edge,
  // so IDLE must wait one more cycle before sampling it.
  assign pcBusy = pcClr_q | pcInc_q | pcLoad_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    memReq_d   = memReq_q;
    memAddr_d  = memAddr_q;
    irOut_d    = irOut_q;
    irValid_d  = irValid_q;
    destReg_d  = destReg_q;
    pcClr_d    = 1'b0;
    pcInc_d    = 1'b0;
    pcLoad_d   = 1'b0;
    fetchErr_d = 1'b0;

    if (bus.Branch_Take) begin
      pcLoad_d  = 1'b1;
      destReg_d = bus.Branch_Target;
      irValid_d = 1'b0;
      memReq_d  = 1'b0;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.Stall && !pcBusy) begin
            memAddr_d = bus.PC_Out;
            memReq_d  = 1'b1;
            count_d   = 8'd0;
            state_d   = FETCH;
          end else begin
            memReq_d  = 1'b0;
          end
        end
        FETCH: begin
          if (bus.Mem_Ack) begin
            irOut_d   = bus.Mem_Data;
            irValid_d = 1'b1;
            memReq_d  = 1'b0;
            pcInc_d   = 1'b1;
            state_d   = HOLD;
          end else if (count_q == 8'(TIMEOUT - 1)) begin
            fetchErr_d = 1'b1;
            memReq_d   = 1'b0;
            state_d    = IDLE;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        HOLD: begin
          if (irValid_q && bus.IR_Ready) begin
            irValid_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: begin
          memReq_d  = 1'b0;
          irValid_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (IF_Clr) begin
      state_q    <= IDLE;
      count_q    <= 8'd0;
      memReq_q   <= 1'b0;
      memAddr_q  <= '0;
      irOut_q    <= '0;
      irValid_q  <= 1'b0;
      pcClr_q    <= 1'b1;
      pcInc_q    <= 1'b0;
      pcLoad_q   <= 1'b0;
      destReg_q  <= '0;
      fetchErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      memReq_q   <= memReq_d;
      memAddr_q  <= memAddr_d;
      irOut_q    <= irOut_d;
      irValid_q  <= irValid_d;
      pcClr_q    <= pcClr_d;
      pcInc_q    <= pcInc_d;
      pcLoad_q   <= pcLoad_d;
      destReg_q  <= destReg_d;
      fetchErr_q <= fetchErr_d;
    end
  end

  assign bus.Mem_Req   = memReq_q;
  assign bus.Mem_Addr  = memAddr_q;
  assign bus.IR_Out    = irOut_q;
  assign bus.IR_Valid  = irValid_q;
  assign bus.PC_Clr    = pcClr_q;
  assign bus.PC_Inc    = pcInc_q;
  assign bus.PC_Load   = pcLoad_q;
  assign bus.Dest_Reg  = destReg_q;
  assign bus.Fetch_Err = fetchErr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small PC register model reacts to the clear/
// increment/load requests while a linear script drives memory, branch and decode.
module tb_instr_fetch;

  logic Clk;
  logic IF_Clr;
  int   checks;
  int   failures;

  instr_fetch_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) bus ();

  instr_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .TIMEOUT(8)) dut (
    .Clk    (Clk),
    .IF_Clr (IF_Clr),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Program counter as the surrounding pipeline would implement it.
  initial bus.PC_Out = 8'h55;
  always @(posedge Clk) begin
    if (bus.PC_Clr)       bus.PC_Out <= 8'h00;
    else if (bus.PC_Load) bus.PC_Out <= bus.Dest_Reg;
    else if (bus.PC_Inc)  bus.PC_Out <= bus.PC_Out + 8'h01;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s differs", tag);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each; PC_Inc and
  // PC_Load must be exclusive on every cycle.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      checkOutput("incLoadExclusive", {31'd0, bus.PC_Inc & bus.PC_Load}, 32'd0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    IF_Clr            = 1'b1;
    bus.Stall         = 1'b1;
    bus.Branch_Take   = 1'b0;
    bus.Branch_Target = 8'h00;
    bus.Mem_Ack       = 1'b0;
    bus.Mem_Data      = 16'h0000;
    bus.IR_Ready      = 1'b1;

    // Reset state
    applyStimulus(2);
    checkOutput("rstPcClr",    {31'd0, bus.PC_Clr},    32'd1);
    checkOutput("rstMemReq",   {31'd0, bus.Mem_Req},   32'd0);
    checkOutput("rstIrValid",  {31'd0, bus.IR_Valid},  32'd0);
    checkOutput("rstFetchErr", {31'd0, bus.Fetch_Err}, 32'd0);
    checkOutput("rstMemAddr",  {24'd0, bus.Mem_Addr},  32'h0);
    checkOutput("rstIrOut",    {16'd0, bus.IR_Out},    32'h0);
    checkOutput("rstDestReg",  {24'd0, bus.Dest_Reg},  32'h0);

    // First edge after release: PC_Clr drops, no fetch yet
    IF_Clr    = 1'b0;
    bus.Stall = 1'b0;
    applyStimulus(1);
    checkOutput("relPcClr",  {31'd0, bus.PC_Clr},  32'd0);
    checkOutput("relMemReq", {31'd0, bus.Mem_Req}, 32'd0);

    // Basic fetch from 0x00, ack two cycles after request
    applyStimulus(1);
    checkOutput("f0MemReq",  {31'd0, bus.Mem_Req}, 32'd1);
    checkOutput("f0MemAddr", {24'd0, bus.Mem_Addr}, 32'h00);
    applyStimulus(1);
    checkOutput("f0ReqHeld", {31'd0, bus.Mem_Req}, 32'd1);
    bus.Mem_Ack  = 1'b1;
    bus.Mem_Data = 16'hA5A5;
    applyStimulus(1);
    bus.Mem_Ack  = 1'b0;
    bus.Mem_Data = 16'hFFFF;
    checkOutput("f0IrOut",   {16'd0, bus.IR_Out},   32'hA5A5);
    checkOutput("f0IrValid", {31'd0, bus.IR_Valid}, 32'd1);
    checkOutput("f0PcInc",   {31'd0, bus.PC_Inc},   32'd1);
    checkOutput("f0ReqDrop", {31'd0, bus.Mem_Req},  32'd0);
    applyStimulus(1);
    checkOutput("f0IrValidLow", {31'd0, bus.IR_Valid}, 32'd0);
    checkOutput("f0PcIncPulse", {31'd0, bus.PC_Inc},   32'd0);
    checkOutput("f0IdleNoReq",  {31'd0, bus.Mem_Req},  32'd0);
    checkOutput("f0IrKept",     {16'd0, bus.IR_Out},   32'hA5A5);
    applyStimulus(1);
    checkOutput("f1MemReq",  {31'd0, bus.Mem_Req},  32'd1);
    checkOutput("f1MemAddr", {24'd0, bus.Mem_Addr}, 32'h01);

    // Backpressure: decode not ready for 5 cycles
    bus.IR_Ready = 1'b0;
    bus.Mem_Ack  = 1'b1;
    bus.Mem_Data = 16'h1234;
    applyStimulus(1);
    bus.Mem_Ack  = 1'b0;
    bus.Mem_Data = 16'h0F0F;
    checkOutput("bpIrValid", {31'd0, bus.IR_Valid}, 32'd1);
    checkOutput("bpIrOut",   {16'd0, bus.IR_Out},   32'h1234);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("bpHoldValid", {31'd0, bus.IR_Valid}, 32'd1);
      checkOutput("bpHoldIr",    {16'd0, bus.IR_Out},   32'h1234);
      checkOutput("bpHoldNoReq", {31'd0, bus.Mem_Req},  32'd0);
      checkOutput("bpHoldNoInc", {31'd0, bus.PC_Inc},   32'd0);
    end
    bus.IR_Ready = 1'b1;
    applyStimulus(1);
    checkOutput("bpReleased", {31'd0, bus.IR_Valid}, 32'd0);
    applyStimulus(1);
    checkOutput("f2MemReq",  {31'd0, bus.Mem_Req},  32'd1);
    checkOutput("f2MemAddr", {24'd0, bus.Mem_Addr}, 32'h02);

    // Branch during FETCH redirects PC to 0x10
    bus.Branch_Take   = 1'b1;
    bus.Branch_Target = 8'h10;
    applyStimulus(1);
    bus.Branch_Take   = 1'b0;
    checkOutput("brPcLoad",  {31'd0, bus.PC_Load},  32'd1);
    checkOutput("brDestReg", {24'd0, bus.Dest_Reg}, 32'h10);
    checkOutput("brNoReq",   {31'd0, bus.Mem_Req},  32'd0);
    applyStimulus(1);
    checkOutput("brLoadPulse", {31'd0, bus.PC_Load}, 32'd0);
    checkOutput("brSettle",    {31'd0, bus.Mem_Req}, 32'd0);
    applyStimulus(1);
    checkOutput("toMemReq",  {31'd0, bus.Mem_Req},  32'd1);
    checkOutput("toMemAddr", {24'd0, bus.Mem_Addr}, 32'h10);

    // Timeout: no ack, Fetch_Err 8 cycles after request rise
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1);
      checkOutput("toWaitErr",  {31'd0, bus.Fetch_Err}, 32'd0);
      checkOutput("toWaitReq",  {31'd0, bus.Mem_Req},   32'd1);
      checkOutput("toWaitAddr", {24'd0, bus.Mem_Addr},  32'h10);
    end
    applyStimulus(1);
    checkOutput("toFetchErr", {31'd0, bus.Fetch_Err}, 32'd1);
    checkOutput("toReqDrop",  {31'd0, bus.Mem_Req},   32'd0);
    checkOutput("toNoInc",    {31'd0, bus.PC_Inc},    32'd0);
    applyStimulus(1);
    checkOutput("toErrPulse",  {31'd0, bus.Fetch_Err}, 32'd0);
    checkOutput("toRetryReq",  {31'd0, bus.Mem_Req},   32'd1);
    checkOutput("toRetryAddr", {24'd0, bus.Mem_Addr},  32'h10);

    // Branch coincident with ack: ack discarded
    applyStimulus(1);
    bus.Mem_Ack       = 1'b1;
    bus.Mem_Data      = 16'hBEEF;
    bus.Branch_Take   = 1'b1;
    bus.Branch_Target = 8'h3C;
    applyStimulus(1);
    bus.Mem_Ack       = 1'b0;
    bus.Branch_Take   = 1'b0;
    checkOutput("colPcLoad",  {31'd0, bus.PC_Load},   32'd1);
    checkOutput("colDestReg", {24'd0, bus.Dest_Reg},  32'h3C);
    checkOutput("colNoInc",   {31'd0, bus.PC_Inc},    32'd0);
    checkOutput("colNoValid", {31'd0, bus.IR_Valid},  32'd0);
    checkOutput("colNoErr",   {31'd0, bus.Fetch_Err}, 32'd0);
    checkOutput("colIrKept",  {16'd0, bus.IR_Out},    32'h1234);
    applyStimulus(2);
    checkOutput("colNextReq",  {31'd0, bus.Mem_Req},  32'd1);
    checkOutput("colNextAddr", {24'd0, bus.Mem_Addr}, 32'h3C);

    // Stall does not abort FETCH or HOLD
    bus.Stall = 1'b1;
    applyStimulus(1);
    checkOutput("stFetchKept", {31'd0, bus.Mem_Req}, 32'd1);
    bus.Mem_Ack  = 1'b1;
    bus.Mem_Data = 16'h5A5A;
    applyStimulus(1);
    bus.Mem_Ack  = 1'b0;
    checkOutput("stAckValid", {31'd0, bus.IR_Valid}, 32'd1);
    checkOutput("stAckIr",    {16'd0, bus.IR_Out},   32'h5A5A);
    applyStimulus(1);
    checkOutput("stHoldDone", {31'd0, bus.IR_Valid}, 32'd0);

    // Stall in IDLE for 4 cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("stIdleNoReq", {31'd0, bus.Mem_Req}, 32'd0);
    end
    bus.Stall = 1'b0;
    applyStimulus(1);
    checkOutput("stResumeReq",  {31'd0, bus.Mem_Req},  32'd1);
    checkOutput("stResumeAddr", {24'd0, bus.Mem_Addr}, 32'h3D);

    // Clear mid-FETCH with a concurrent ack
    IF_Clr       = 1'b1;
    bus.Mem_Ack  = 1'b1;
    bus.Mem_Data = 16'hCAFE;
    applyStimulus(1);
    IF_Clr       = 1'b0;
    bus.Mem_Ack  = 1'b0;
    checkOutput("clrMemReq",  {31'd0, bus.Mem_Req},  32'd0);
    checkOutput("clrPcClr",   {31'd0, bus.PC_Clr},   32'd1);
    checkOutput("clrIrValid", {31'd0, bus.IR_Valid}, 32'd0);
    checkOutput("clrNoInc",   {31'd0, bus.PC_Inc},   32'd0);
    checkOutput("clrIrOut",   {16'd0, bus.IR_Out},   32'h0);
    applyStimulus(1);
    checkOutput("clrRelPcClr",  {31'd0, bus.PC_Clr},  32'd0);
    checkOutput("clrRelNoReq",  {31'd0, bus.Mem_Req}, 32'd0);
    applyStimulus(1);
    checkOutput("clrRefetchReq",  {31'd0, bus.Mem_Req},  32'd1);
    checkOutput("clrRefetchAddr", {24'd0, bus.Mem_Addr}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
